// File: rtl/brownout_monitor.sv
// Brown-out supervisor: sequences detector enable/settle, filters its flags, raises timed reset requests.
// Latency: sys_rst_req follows bo_out by DEBOUNCE+2 cycles; outputs registered off the next state.
// Backpressure: none; cfg_we outside OFF/MONITOR is dropped and reported on cfg_rej.

module brownout_sync_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            // dout moves only after DEBOUNCE consecutive disagreeing samples
            if (sync[1] != dout) begin
                if (cnt == DW'(DEBOUNCE - 1)) begin
                    dout <= sync[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module brownout_monitor #(
    parameter int SETTLE_CYCLES = 64,
    parameter int DEBOUNCE      = 4,
    parameter int HOLD_CYCLES   = 256,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_ena,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_otrip,
    input  logic [2:0]       cfg_vtrip,
    input  logic             clr_flags,
    input  logic             bo_out,
    input  logic             bo_vunder,
    output logic             bo_ena,
    output logic [2:0]       bo_otrip,
    output logic [2:0]       bo_vtrip,
    output logic             sys_rst_req,
    output logic             pwr_good,
    output logic             brout_flag,
    output logic             vunder_flag,
    output logic [CNT_W-1:0] brout_count,
    output logic             cfg_rej
);
    localparam int TMAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_SETTLE,
        S_MONITOR,
        S_FAULT,
        S_HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          db_out, db_vun, db_vun_q;
    logic          accept_we, fault_entry, vun_rise;

    brownout_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_out (
        .clk(clk), .rst(rst), .din(bo_out), .dout(db_out)
    );

    brownout_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_vun (
        .clk(clk), .rst(rst), .din(bo_vunder), .dout(db_vun)
    );

    assign accept_we   = cfg_we && (state == S_OFF || state == S_MONITOR);
    assign fault_entry = (state_nxt == S_FAULT) && (state != S_FAULT);
    assign vun_rise    = db_vun && !db_vun_q &&
                         (state == S_MONITOR || state == S_FAULT || state == S_HOLD);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        if (!cfg_ena) begin
            state_nxt = S_OFF;
        end else begin
            case (state)
                S_OFF: begin
                    state_nxt = S_SETTLE;
                    timer_nxt = TW'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (timer == '0) state_nxt = db_out ? S_FAULT : S_MONITOR;
                    else             timer_nxt = timer - 1'b1;
                end
                S_MONITOR: begin
                    // A trip-code change invalidates the detector output until it resettles
                    if (cfg_we) begin
                        state_nxt = S_SETTLE;
                        timer_nxt = TW'(SETTLE_CYCLES - 1);
                    end else if (db_out) begin
                        state_nxt = S_FAULT;
                    end
                end
                S_FAULT: begin
                    if (!db_out) begin
                        state_nxt = S_HOLD;
                        timer_nxt = TW'(HOLD_CYCLES - 1);
                    end
                end
                S_HOLD: begin
                    if (db_out)             state_nxt = S_FAULT;
                    else if (timer == '0)   state_nxt = S_MONITOR;
                    else                    timer_nxt = timer - 1'b1;
                end
                default: state_nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_OFF;
            timer       <= '0;
            db_vun_q    <= 1'b0;
            bo_ena      <= 1'b0;
            bo_otrip    <= '0;
            bo_vtrip    <= '0;
            sys_rst_req <= 1'b0;
            pwr_good    <= 1'b0;
            brout_flag  <= 1'b0;
            vunder_flag <= 1'b0;
            brout_count <= '0;
            cfg_rej     <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            db_vun_q    <= db_vun;
            bo_ena      <= (state_nxt != S_OFF);
            pwr_good    <= (state_nxt == S_MONITOR);
            sys_rst_req <= (state_nxt == S_FAULT) || (state_nxt == S_HOLD);
            cfg_rej     <= cfg_we && !accept_we;
            if (accept_we) begin
                bo_otrip <= cfg_otrip;
                bo_vtrip <= cfg_vtrip;
            end
            // A new event in the clearing cycle survives the clear
            if (fault_entry) begin
                brout_flag <= 1'b1;
                if (clr_flags)         brout_count <= CNT_W'(1);
                else if (!(&brout_count)) brout_count <= brout_count + 1'b1;
            end else if (clr_flags) begin
                brout_flag  <= 1'b0;
                brout_count <= '0;
            end
            if (vun_rise)       vunder_flag <= 1'b1;
            else if (clr_flags) vunder_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_brownout_monitor.sv
// Directed bench for brownout_monitor: default instance plus a small instance for saturation.
module tb_brownout_monitor;
    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_ena, cfg_we, clr_flags, bo_out, bo_vunder;
    logic [2:0] cfg_otrip, cfg_vtrip;
    logic       bo_ena, sys_rst_req, pwr_good, brout_flag, vunder_flag, cfg_rej;
    logic [2:0] bo_otrip, bo_vtrip;
    logic [7:0] brout_count;

    logic       s_ena, s_clr, s_bo_out;
    logic       s_bo_ena, s_rst_req, s_pwr_good, s_flag, s_vflag, s_rej;
    logic [2:0] s_otrip, s_vtrip;
    logic [1:0] s_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    brownout_monitor dut (
        .clk(clk), .rst(rst), .cfg_ena(cfg_ena), .cfg_we(cfg_we),
        .cfg_otrip(cfg_otrip), .cfg_vtrip(cfg_vtrip), .clr_flags(clr_flags),
        .bo_out(bo_out), .bo_vunder(bo_vunder), .bo_ena(bo_ena),
        .bo_otrip(bo_otrip), .bo_vtrip(bo_vtrip), .sys_rst_req(sys_rst_req),
        .pwr_good(pwr_good), .brout_flag(brout_flag), .vunder_flag(vunder_flag),
        .brout_count(brout_count), .cfg_rej(cfg_rej)
    );

    brownout_monitor #(.SETTLE_CYCLES(2), .DEBOUNCE(1), .HOLD_CYCLES(2), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .cfg_ena(s_ena), .cfg_we(1'b0),
        .cfg_otrip(3'b000), .cfg_vtrip(3'b000), .clr_flags(s_clr),
        .bo_out(s_bo_out), .bo_vunder(1'b0), .bo_ena(s_bo_ena),
        .bo_otrip(s_otrip), .bo_vtrip(s_vtrip), .sys_rst_req(s_rst_req),
        .pwr_good(s_pwr_good), .brout_flag(s_flag), .vunder_flag(s_vflag),
        .brout_count(s_count), .cfg_rej(s_rej)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_ena = 0; cfg_we = 0; clr_flags = 0; bo_out = 0; bo_vunder = 0;
        cfg_otrip = 0; cfg_vtrip = 0; s_ena = 0; s_clr = 0; s_bo_out = 0;
        tick(2);
        rst = 1'b0;
        tick(1);
        tests++; if ({bo_ena, sys_rst_req, pwr_good, cfg_rej} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctl: got %b expected 0000", {bo_ena, sys_rst_req, pwr_good, cfg_rej}); end
        tests++; if ({bo_otrip, bo_vtrip} !== 6'd0) begin
            fails++; $display("FAIL reset_trip: got %b expected 000000", {bo_otrip, bo_vtrip}); end
        tests++; if ({brout_flag, vunder_flag, brout_count} !== 10'd0) begin
            fails++; $display("FAIL reset_flags: got %h expected 0", {brout_flag, vunder_flag, brout_count}); end
    endtask

    task automatic test_enable;
        cfg_ena = 1'b1;
        tick(1);
        tests++; if (bo_ena !== 1'b1 || pwr_good !== 1'b0) begin
            fails++; $display("FAIL enable_bo_ena: got ena=%b pg=%b expected ena=1 pg=0", bo_ena, pwr_good); end
        tick(63);
        tests++; if (pwr_good !== 1'b0) begin
            fails++; $display("FAIL enable_settle64: got pwr_good=%b expected 0", pwr_good); end
        tick(1);
        tests++; if (pwr_good !== 1'b1 || brout_count !== 8'd0 || sys_rst_req !== 1'b0) begin
            fails++; $display("FAIL enable_pg65: got pg=%b cnt=%0d rr=%b expected pg=1 cnt=0 rr=0",
                              pwr_good, brout_count, sys_rst_req); end
    endtask

    task automatic test_glitch;
        int drops;
        drops = 0;
        bo_out = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(1); if (pwr_good !== 1'b1) drops++; end
        bo_out = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(1); if (pwr_good !== 1'b1) drops++; end
        tests++; if (drops !== 0) begin
            fails++; $display("FAIL glitch_pg: got %0d cycles without pwr_good expected 0", drops); end
        tests++; if (brout_flag !== 1'b0 || sys_rst_req !== 1'b0) begin
            fails++; $display("FAIL glitch_flag: got flag=%b rr=%b expected 0 0", brout_flag, sys_rst_req); end
    endtask

    task automatic test_brownout;
        bo_out = 1'b1;
        tick(6);
        tests++; if (sys_rst_req !== 1'b0 || pwr_good !== 1'b1) begin
            fails++; $display("FAIL bo_early: got rr=%b pg=%b expected rr=0 pg=1", sys_rst_req, pwr_good); end
        tick(1);
        tests++; if (sys_rst_req !== 1'b1 || pwr_good !== 1'b0) begin
            fails++; $display("FAIL bo_latency: got rr=%b pg=%b expected rr=1 pg=0", sys_rst_req, pwr_good); end
        tests++; if (brout_count !== 8'd1 || brout_flag !== 1'b1) begin
            fails++; $display("FAIL bo_count: got cnt=%0d flag=%b expected cnt=1 flag=1", brout_count, brout_flag); end
        tick(13);
        bo_out = 1'b0;
        tick(262);
        tests++; if (pwr_good !== 1'b0 || sys_rst_req !== 1'b1) begin
            fails++; $display("FAIL release_early: got pg=%b rr=%b expected pg=0 rr=1", pwr_good, sys_rst_req); end
        tick(1);
        tests++; if (pwr_good !== 1'b1 || sys_rst_req !== 1'b0) begin
            fails++; $display("FAIL release_263: got pg=%b rr=%b expected pg=1 rr=0", pwr_good, sys_rst_req); end
    endtask

    task automatic test_reassert_hold;
        bo_out = 1'b1;
        tick(20);
        bo_out = 1'b0;
        tick(107);
        bo_out = 1'b1;
        tick(6);
        tests++; if (brout_count !== 8'd2 || sys_rst_req !== 1'b1) begin
            fails++; $display("FAIL hold_pre: got cnt=%0d rr=%b expected cnt=2 rr=1", brout_count, sys_rst_req); end
        tick(1);
        tests++; if (brout_count !== 8'd3) begin
            fails++; $display("FAIL hold_reassert: got cnt=%0d expected 3", brout_count); end
        tick(10);
        bo_out = 1'b0;
        tick(262);
        tests++; if (pwr_good !== 1'b0) begin
            fails++; $display("FAIL hold_restart: got pg=%b expected 0", pwr_good); end
        tick(1);
        tests++; if (pwr_good !== 1'b1) begin
            fails++; $display("FAIL hold_done: got pg=%b expected 1", pwr_good); end
    endtask

    task automatic test_cfg;
        cfg_otrip = 3'b101; cfg_vtrip = 3'b011; cfg_we = 1'b1;
        tick(1);
        cfg_we = 1'b0;
        tests++; if (bo_otrip !== 3'b101 || bo_vtrip !== 3'b011 || cfg_rej !== 1'b0) begin
            fails++; $display("FAIL cfg_load: got o=%b v=%b rej=%b expected o=101 v=011 rej=0",
                              bo_otrip, bo_vtrip, cfg_rej); end
        tests++; if (pwr_good !== 1'b0 || bo_ena !== 1'b1) begin
            fails++; $display("FAIL cfg_settle: got pg=%b ena=%b expected pg=0 ena=1", pwr_good, bo_ena); end
        tick(63);
        tests++; if (pwr_good !== 1'b0) begin
            fails++; $display("FAIL cfg_settle64: got pg=%b expected 0", pwr_good); end
        tick(1);
        tests++; if (pwr_good !== 1'b1) begin
            fails++; $display("FAIL cfg_monitor: got pg=%b expected 1", pwr_good); end
    endtask

    task automatic test_cfg_rej;
        bo_out = 1'b1;
        tick(7);
        cfg_otrip = 3'b010; cfg_vtrip = 3'b111; cfg_we = 1'b1;
        tick(1);
        cfg_we = 1'b0;
        tests++; if (cfg_rej !== 1'b1 || bo_otrip !== 3'b101 || bo_vtrip !== 3'b011) begin
            fails++; $display("FAIL rej_pulse: got rej=%b o=%b v=%b expected rej=1 o=101 v=011",
                              cfg_rej, bo_otrip, bo_vtrip); end
        tick(1);
        tests++; if (cfg_rej !== 1'b0) begin
            fails++; $display("FAIL rej_one_cycle: got rej=%b expected 0", cfg_rej); end
        bo_out = 1'b0;
        tick(263);
        tests++; if (pwr_good !== 1'b1 || brout_count !== 8'd4) begin
            fails++; $display("FAIL rej_recover: got pg=%b cnt=%0d expected pg=1 cnt=4", pwr_good, brout_count); end
    endtask

    task automatic test_vunder_clr;
        bo_vunder = 1'b1;
        tick(6);
        tests++; if (vunder_flag !== 1'b0) begin
            fails++; $display("FAIL vun_early: got %b expected 0", vunder_flag); end
        tick(1);
        tests++; if (vunder_flag !== 1'b1 || sys_rst_req !== 1'b0) begin
            fails++; $display("FAIL vun_set: got flag=%b rr=%b expected 1 0", vunder_flag, sys_rst_req); end
        bo_vunder = 1'b0;
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        tests++; if ({brout_flag, vunder_flag, brout_count} !== 10'd0) begin
            fails++; $display("FAIL clr: got %h expected 0", {brout_flag, vunder_flag, brout_count}); end
    endtask

    task automatic test_off_with_we;
        cfg_ena = 1'b0; cfg_we = 1'b1; cfg_otrip = 3'b110; cfg_vtrip = 3'b001;
        tick(1);
        cfg_we = 1'b0;
        tests++; if (bo_ena !== 1'b0 || pwr_good !== 1'b0 || bo_otrip !== 3'b110 || bo_vtrip !== 3'b001) begin
            fails++; $display("FAIL off_we: got ena=%b pg=%b o=%b v=%b expected 0 0 110 001",
                              bo_ena, pwr_good, bo_otrip, bo_vtrip); end
    endtask

    task automatic test_saturate;
        s_ena = 1'b1;
        tick(3);
        tests++; if (s_pwr_good !== 1'b1) begin
            fails++; $display("FAIL sat_enable: got pg=%b expected 1", s_pwr_good); end
        for (int i = 0; i < 5; i++) begin
            s_bo_out = 1'b1; tick(4);
            s_bo_out = 1'b0; tick(8);
        end
        tests++; if (s_count !== 2'd3 || s_flag !== 1'b1) begin
            fails++; $display("FAIL sat_count: got cnt=%0d flag=%b expected 3 1", s_count, s_flag); end
        s_bo_out = 1'b1;
        tick(3);
        tests++; if (s_rst_req !== 1'b0) begin
            fails++; $display("FAIL sat_latency: got rr=%b expected 0", s_rst_req); end
        s_clr = 1'b1;
        tick(1);
        s_clr = 1'b0;
        tests++; if (s_count !== 2'd1 || s_flag !== 1'b1 || s_rst_req !== 1'b1) begin
            fails++; $display("FAIL clr_vs_set: got cnt=%0d flag=%b rr=%b expected 1 1 1", s_count, s_flag, s_rst_req); end
        s_bo_out = 1'b0;
    endtask

    task automatic test_mid_reset;
        cfg_ena = 1'b1;
        tick(65);
        bo_out = 1'b1;
        tick(7);
        tests++; if (sys_rst_req !== 1'b1) begin
            fails++; $display("FAIL midrst_pre: got rr=%b expected 1", sys_rst_req); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++; if ({bo_ena, sys_rst_req, pwr_good, brout_flag, brout_count, bo_otrip} !== 15'd0) begin
            fails++; $display("FAIL midrst: got %h expected 0",
                              {bo_ena, sys_rst_req, pwr_good, brout_flag, brout_count, bo_otrip}); end
        bo_out = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_enable();
        test_glitch();
        test_brownout();
        test_reassert_hold();
        test_cfg();
        test_cfg_rej();
        test_vunder_clr();
        test_off_with_we();
        test_saturate();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/brownout_monitor.md
# brownout_monitor

Digital supervisor that consumes the brownout detector's outputs and drives its control inputs. It sequences detector enable and settling, synchronizes and debounces the asynchronous `out`/`vunder` flags into the `clk` domain, and turns brown-out events into a timed system reset request. It also keeps sticky event flags and a saturating event count. It sits in the dvdd domain between the system controller and the brownout macro.

## Interface
- `SETTLE_CYCLES`, 64: cycles after enable or trip change before detector outputs are trusted (≥1)
- `DEBOUNCE`, 4: consecutive identical synchronized samples needed to change a debounced level (≥1)
- `HOLD_CYCLES`, 256: reset-hold time after brown-out clears (≥1)
- `CNT_W`, 8: event counter width

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `cfg_ena` in 1: supervisor/detector enable level
- `cfg_we` in 1: single-cycle strobe that requests loading `cfg_otrip`/`cfg_vtrip`
- `cfg_otrip` in 3: brown-out trip code
- `cfg_vtrip` in 3: under-voltage trip code
- `clr_flags` in 1: clears flags and count
- `bo_out` in 1: detector brown-out output, asynchronous
- `bo_vunder` in 1: detector under-voltage output, asynchronous
- `bo_ena` out 1: detector enable
- `bo_otrip` out 3: registered trip code to detector
- `bo_vtrip` out 3: registered trip code to detector
- `sys_rst_req` out 1: system reset request
- `pwr_good` out 1: high only in MONITOR
- `brout_flag` out 1: sticky brown-out seen
- `vunder_flag` out 1: sticky under-voltage seen
- `brout_count` out CNT_W: saturating brown-out event count
- `cfg_rej` out 1: one-cycle pulse when `cfg_we` is ignored

## Operation
- Synchronization and debounce:
  - Each of `bo_out` and `bo_vunder` passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level (`db_out`, `db_vun`) changes only after `DEBOUNCE` consecutive synchronized samples differ from it.
- FSM states and transitions:
  - OFF: `bo_ena`=0. Goes to SETTLE when `cfg_ena`=1, loading the settle counter.
  - SETTLE: `bo_ena`=1 and detector outputs are ignored for exactly `SETTLE_CYCLES` cycles. At expiry, goes to FAULT if `db_out`=1, otherwise to MONITOR.
  - MONITOR: `pwr_good`=1. Goes to FAULT when `db_out` rises.
  - FAULT: `sys_rst_req`=1. Goes to HOLD when `db_out`=0, loading the hold counter.
  - HOLD: `sys_rst_req`=1. Goes back to FAULT if `db_out`=1. Goes to MONITOR after `HOLD_CYCLES`.
- `cfg_ena`=0 forces OFF on the next edge from any state. This has top priority.
- Every entry into FAULT (from MONITOR, SETTLE, or HOLD) sets `brout_flag` and increments `brout_count`. The count saturates at all-ones.
- `vunder_flag` is set on a rising edge of `db_vun` in MONITOR, FAULT, or HOLD. It is never set in OFF or SETTLE.
- `clr_flags` clears both flags and the count. If a set or increment happens in the same cycle, the set wins and the count becomes 1.
- `cfg_we` handling:
  - Accepted in OFF or MONITOR: `bo_otrip`/`bo_vtrip` load on that edge.
  - If accepted in MONITOR, the FSM also returns to SETTLE and the settle counter restarts.
  - Ignored in SETTLE, FAULT, or HOLD: registers are unchanged and `cfg_rej` pulses for 1 cycle.
  - If `cfg_we` and `cfg_ena`=0 arrive together in MONITOR, the FSM goes to OFF and the trip registers still load.
- All outputs are registered and decoded from the state.

## Timing
- Reset values:
  - State OFF.
  - All outputs 0: `bo_ena`, `bo_otrip`, `bo_vtrip`, `sys_rst_req`, `pwr_good`, both flags, `brout_count`, `cfg_rej`.
  - Synchronizers, debouncers, and counters cleared.
- `bo_ena` rises 1 cycle after the edge that samples `cfg_ena`=1.
- `pwr_good` rises `SETTLE_CYCLES`+1 cycles after that edge if `db_out`=0.
- Brown-out latency: `sys_rst_req` rises, and `pwr_good` falls, exactly `DEBOUNCE`+2 cycles after the first edge that samples `bo_out`=1, provided `bo_out` is held. This is 6 cycles at the defaults.
- Release latency: after `bo_out` falls, `db_out` clears after `DEBOUNCE`+2 cycles. `sys_rst_req` then stays high for 1 FAULT→HOLD cycle plus `HOLD_CYCLES` before `pwr_good` rises.
- Pulses on `bo_out` shorter than `DEBOUNCE` synchronized samples never reach FAULT.
- `rst` mid-operation returns to the reset values on the next edge, including deassertion of `sys_rst_req`.

## Test plan
- Enable path: `rst`, then `cfg_ena`=1 with `bo_out`=0 → `bo_ena`=1 after 1 cycle, `pwr_good`=1 after 65 cycles, `brout_count`=0.
- Glitch filtering: in MONITOR, `bo_out`=1 for 3 cycles → no FAULT, `pwr_good` stays 1, `brout_flag`=0.
- Sustained brown-out and release:
  - In MONITOR, `bo_out`=1 for 20 cycles → `sys_rst_req`=1 after 6 cycles, `brout_count`=1, `brout_flag`=1.
  - After `bo_out` falls → `pwr_good`=1 after 6+1+256 cycles.
- Reassert during hold: `bo_out` reasserts 100 cycles into HOLD → FAULT, `brout_count`=2, hold restarts in full after the next release.
- Configuration:
  - `cfg_we` in MONITOR with `cfg_otrip`=3'b101 → `bo_otrip`=3'b101 next cycle, state SETTLE, `pwr_good`=0 for 64 cycles.
  - `cfg_we` in FAULT → `cfg_rej` pulses 1 cycle and `bo_otrip` is unchanged.
- Saturation and clear: with `CNT_W`=2, drive 5 events → count stays 3. Assert `clr_flags` on the cycle of a new FAULT entry → count=1, `brout_flag`=1.
